// File: rtl/spi_pkg.sv
// Shared SPI definitions for the stepper controller's responder and initiator-side blocks.
package spi_pkg;

  localparam int unsigned SPI_FRAME_BITS = 40;

  // Mode 3: clock idles high, data captured on the rising edge
  localparam logic SPI_CPOL = 1'b1;
  localparam logic SPI_CPHA = 1'b1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/spi_responder_sync_edge.sv
// Multi-flop synchronizer with a delay flop for single-cycle rise/fall event pulses.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic sig_in,
  output logic level_out,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   dly;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      dly   <= RESET_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], sig_in};
      dly   <= chain[SYNC_STAGES-1];
    end
  end

  assign level_out = chain[SYNC_STAGES-1];
  assign rise_c    = level_out & ~dly;
  assign fall_c    = ~level_out & dly;

endmodule

// File: rtl/spi_responder.sv
// Mode-3 SPI responder: oversampled SCK/CS_n/MOSI, fixed-length rx frame, parallel status word on MISO.
module spi_responder
  import spi_pkg::*;
#(
  parameter int unsigned SIZE        = SPI_FRAME_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            sck_in,
  input  logic            cs_n_in,
  input  logic            mosi_in,
  output logic            miso_out,
  output logic            miso_oe_out,
  input  logic [SIZE-1:0] tx_data_in,
  output logic [SIZE-1:0] rx_data_out,
  output logic            rx_valid_out,
  output logic            rx_error_out,
  output logic            busy_out
);

  localparam int unsigned CNT_W    = $clog2(SIZE + 2);
  localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 2);

  localparam logic [CNT_W-1:0]    CNT_FULL    = CNT_W'(SIZE);
  localparam logic [CNT_W-1:0]    CNT_SAT     = CNT_W'(SIZE + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_lvl;

  logic [0:0]          state, state_d;
  logic [SIZE-1:0]     tx_shift, tx_d;
  logic [SIZE-1:0]     rx_shift, rx_d;
  logic [CNT_W-1:0]    bit_cnt, cnt_d;
  logic                first_fall, first_fall_d;
  logic [SETTLE_W-1:0] settle_cnt, settle_d;
  logic                armed, armed_d;
  logic [SIZE-1:0]     data_d;
  logic                valid_d, err_d, busy_d, miso_d;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sck_sync (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .sig_in    (sck_in),
    .level_out (sck_lvl),
    .rise_c    (sck_rise),
    .fall_c    (sck_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .sig_in    (cs_n_in),
    .level_out (cs_lvl),
    .rise_c    (cs_rise),
    .fall_c    (cs_fall)
  );

  // MOSI only needs the level; same depth keeps it aligned with the SCK edge pulses
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) mosi_sync <= '0;
    else           mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
  end

  assign mosi_lvl = mosi_sync[SYNC_STAGES-1];

  always_comb begin
    state_d      = state;
    tx_d         = tx_shift;
    rx_d         = rx_shift;
    cnt_d        = bit_cnt;
    first_fall_d = first_fall;
    settle_d     = settle_cnt;
    armed_d      = armed;
    data_d       = rx_data_out;
    valid_d      = 1'b0;
    err_d        = 1'b0;

    // Reset values must drain out of the synchronizers before an idle bus can arm us
    if (settle_cnt != SETTLE_DONE) settle_d = settle_cnt + SETTLE_W'(1);
    else if (cs_lvl && (sck_lvl == SPI_CPOL)) armed_d = 1'b1;

    case (state)
      ST_IDLE: begin
        if (armed && cs_fall) begin
          state_d      = ST_ACTIVE;
          tx_d         = tx_data_in;
          cnt_d        = '0;
          first_fall_d = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // Deselect wins over any SCK edge landing in the same cycle
        if (cs_rise) begin
          state_d = ST_IDLE;
          if (bit_cnt == CNT_FULL) begin
            data_d  = rx_shift;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          if (sck_rise) begin
            rx_d = {rx_shift[SIZE-2:0], mosi_lvl};
            if (bit_cnt != CNT_SAT) cnt_d = bit_cnt + CNT_W'(1);
          end
          if (sck_fall) begin
            if (first_fall) first_fall_d = 1'b0;
            else            tx_d = {tx_shift[SIZE-2:0], 1'b0};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_ACTIVE);
    miso_d = busy_d & tx_d[SIZE-1];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= ST_IDLE;
      tx_shift     <= '0;
      rx_shift     <= '0;
      bit_cnt      <= '0;
      first_fall   <= 1'b0;
      settle_cnt   <= '0;
      armed        <= 1'b0;
      rx_data_out  <= '0;
      rx_valid_out <= 1'b0;
      rx_error_out <= 1'b0;
      busy_out     <= 1'b0;
      miso_oe_out  <= 1'b0;
      miso_out     <= 1'b0;
    end else begin
      state        <= state_d;
      tx_shift     <= tx_d;
      rx_shift     <= rx_d;
      bit_cnt      <= cnt_d;
      first_fall   <= first_fall_d;
      settle_cnt   <= settle_d;
      armed        <= armed_d;
      rx_data_out  <= data_d;
      rx_valid_out <= valid_d;
      rx_error_out <= err_d;
      busy_out     <= busy_d;
      miso_oe_out  <= busy_d;
      miso_out     <= miso_d;
    end
  end

endmodule

// File: tb/tb_spi_responder.sv
// Randomized frame-level bench for spi_responder with an initiator-side reference model.
module tb_spi_responder;

  localparam int SIZE        = 40;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 4;

  logic            clk_in = 1'b0;
  logic            rst_n_in;
  logic            sck_in, cs_n_in, mosi_in;
  logic            miso_out, miso_oe_out;
  logic [SIZE-1:0] tx_data_in, rx_data_out;
  logic            rx_valid_out, rx_error_out, busy_out;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  logic [SIZE-1:0] exp_rx  = '0;
  logic [SIZE-1:0] last_rx = '0;
  logic            prev_valid = 1'b0;
  logic            prev_err   = 1'b0;
  logic [127:0]    miso_seen;

  always #5 clk_in = ~clk_in;

  spi_responder #(.SIZE(SIZE), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .sck_in       (sck_in),
    .cs_n_in      (cs_n_in),
    .mosi_in      (mosi_in),
    .miso_out     (miso_out),
    .miso_oe_out  (miso_oe_out),
    .tx_data_in   (tx_data_in),
    .rx_data_out  (rx_data_out),
    .rx_valid_out (rx_valid_out),
    .rx_error_out (rx_error_out),
    .busy_out     (busy_out)
  );

  task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Per-cycle checks on the falling clock edge
  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      check({miso_out, miso_oe_out, rx_valid_out, rx_error_out, busy_out} == 5'b0 && rx_data_out == '0,
            "reset_outputs", {miso_out, miso_oe_out, rx_valid_out, rx_error_out, busy_out, rx_data_out}, 0);
      last_rx    = '0;
      prev_valid = 1'b0;
      prev_err   = 1'b0;
    end else begin
      check(busy_out == miso_oe_out, "oe_tracks_busy", miso_oe_out, busy_out);
      check(busy_out || !miso_out, "miso_idle_low", miso_out, 0);
      check(!(rx_valid_out && rx_error_out), "valid_err_exclusive", {rx_valid_out, rx_error_out}, 0);
      if (rx_valid_out) begin
        check(!prev_valid, "valid_width", prev_valid, 0);
        check(rx_data_out == exp_rx, "rx_data", rx_data_out, exp_rx);
        last_rx = exp_rx;
        valid_cnt++;
      end else begin
        check(rx_data_out == last_rx, "rx_hold", rx_data_out, last_rx);
      end
      if (rx_error_out) begin
        check(!prev_err, "err_width", prev_err, 0);
        err_cnt++;
      end
      prev_valid = rx_valid_out;
      prev_err   = rx_error_out;
    end
  end

  // One initiator transaction; coincide raises CS_n together with the last SCK rise
  task automatic run_frame(input string name, input logic [127:0] bits, input int nbits,
                           input logic [SIZE-1:0] tx, input bit coincide,
                           input int chg_idx, input logic [SIZE-1:0] chg_val);
    int eff, v0, e0;
    logic [SIZE-1:0] rx_m;
    logic [127:0] exp_miso;
    eff  = coincide ? nbits - 1 : nbits;
    rx_m = last_rx;
    for (int i = 0; i < eff; i++) rx_m = {rx_m[SIZE-2:0], bits[nbits-1-i]};
    if (eff == SIZE) exp_rx = rx_m;
    exp_miso = '0;
    for (int k = 0; k < nbits; k++) exp_miso = {exp_miso[126:0], (k < SIZE) ? tx[SIZE-1-k] : 1'b0};
    v0 = valid_cnt;
    e0 = err_cnt;
    miso_seen = '0;

    tx_data_in = tx;
    cs_n_in    = 1'b0;
    tick(HALF);
    check(busy_out == 1'b1, {name, "_busy_start"}, busy_out, 1);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_idx) tx_data_in = chg_val;
      sck_in  = 1'b0;
      mosi_in = bits[nbits-1-i];
      tick(HALF);
      sck_in = 1'b1;
      if (coincide && i == nbits - 1) cs_n_in = 1'b1;
      miso_seen = {miso_seen[126:0], miso_out};
      check(busy_out == 1'b1, {name, "_busy"}, busy_out, 1);
      tick(HALF);
    end
    cs_n_in = 1'b1;
    tick(2 * HALF);

    check(miso_seen == exp_miso, {name, "_miso"}, miso_seen, exp_miso);
    check(valid_cnt - v0 == ((eff == SIZE) ? 1 : 0), {name, "_valid_pulses"}, valid_cnt - v0, (eff == SIZE) ? 1 : 0);
    check(err_cnt - e0 == ((eff == SIZE) ? 0 : 1), {name, "_err_pulses"}, err_cnt - e0, (eff == SIZE) ? 0 : 1);
    check(busy_out == 1'b0, {name, "_busy_end"}, busy_out, 0);
  endtask

  task automatic raw_bits(input int n);
    for (int i = 0; i < n; i++) begin
      sck_in  = 1'b0;
      mosi_in = 1'($urandom);
      tick(HALF);
      sck_in = 1'b1;
      tick(HALF);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int v0, e0, nb;
    logic [127:0] rb;
    int len_tab [8] = '{40, 40, 40, 39, 41, 0, 1, 2};

    rst_n_in   = 1'b0;
    sck_in     = 1'b1;
    cs_n_in    = 1'b1;
    mosi_in    = 1'b0;
    tx_data_in = '0;
    tick(3);
    rst_n_in = 1'b1;
    tick(10);

    run_frame("nominal", 128'h80_0000_00FF, 40, 40'hA5_1234_5678, 1'b0, -1, '0);
    check(rx_data_out == 40'h80_0000_00FF, "nominal_rx_literal", rx_data_out, 40'h80_0000_00FF);
    check(miso_seen[39:0] == 40'hA5_1234_5678, "nominal_miso_literal", miso_seen[39:0], 40'hA5_1234_5678);

    run_frame("short", {$urandom, $urandom}, 39, 40'h12_3456_789A, 1'b0, -1, '0);
    check(rx_data_out == 40'h80_0000_00FF, "short_rx_kept", rx_data_out, 40'h80_0000_00FF);

    run_frame("long41", {$urandom, $urandom}, 41, 40'h5A_5A5A_5A5A, 1'b0, -1, '0);
    run_frame("long104", {$urandom, $urandom, $urandom, $urandom}, 104, 40'hC3_0000_0001, 1'b0, -1, '0);
    run_frame("zero_bits", '0, 0, 40'hFF_0000_0000, 1'b0, -1, '0);

    run_frame("coincide", {40'h12_3456_789A, 1'b1}, 41, 40'h0F_F0F0_0F0F, 1'b1, -1, '0);
    check(rx_data_out == 40'h12_3456_789A, "coincide_rx_literal", rx_data_out, 40'h12_3456_789A);

    // Reset while selected mid-frame; the tail of that frame must be ignored
    v0 = valid_cnt;
    e0 = err_cnt;
    cs_n_in = 1'b0;
    tick(HALF);
    raw_bits(20);
    rst_n_in = 1'b0;
    tick(3);
    rst_n_in = 1'b1;
    raw_bits(20);
    cs_n_in = 1'b1;
    tick(2 * HALF);
    check(valid_cnt == v0, "rst_mid_no_valid", valid_cnt - v0, 0);
    check(err_cnt == e0, "rst_mid_no_err", err_cnt - e0, 0);
    check(rx_data_out == '0, "rst_mid_rx_cleared", rx_data_out, 0);
    run_frame("post_reset", 128'h00_DEAD_BEEF, 40, 40'h33_3333_3333, 1'b0, -1, '0);
    check(rx_data_out == 40'h00_DEAD_BEEF, "post_reset_rx_literal", rx_data_out, 40'h00_DEAD_BEEF);

    run_frame("tx_hold", {$urandom, $urandom}, 40, 40'hFF_FFFF_FFFF, 1'b0, 10, 40'h0);
    check(miso_seen[39:0] == 40'hFF_FFFF_FFFF, "tx_hold_literal", miso_seen[39:0], 40'hFF_FFFF_FFFF);
    run_frame("tx_next", {$urandom, $urandom}, 40, 40'h0, 1'b0, -1, '0);
    check(miso_seen[39:0] == 40'h0, "tx_next_literal", miso_seen[39:0], 0);

    for (int r = 0; r < 12; r++) begin
      nb = len_tab[$urandom_range(7, 0)];
      rb = {$urandom, $urandom, $urandom, $urandom};
      if (nb == 41 && $urandom_range(1, 0) == 1)
        run_frame("rand_coincide", rb, nb, SIZE'({$urandom, $urandom}), 1'b1, -1, '0);
      else
        run_frame("rand", rb, nb, SIZE'({$urandom, $urandom}), 1'b0,
                  int'($urandom_range(60, 0)), SIZE'({$urandom, $urandom}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
